// File: rtl/lz77_match_scan_ctrl.sv
// Walks a 64-bit match-candidate mask and emits each set bit's 1-based position, lowest first.
// Optional abort input is enabled by defining LZ77_MATCH_SCAN_ABORT_EN.
module lz77_match_scan_ctrl #(
  parameter int DAT_WD      = 64,
  parameter int POS_WD      = 7,
  parameter int MAX_POS_NUM = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DAT_WD-1:0] mask_i,
`ifdef LZ77_MATCH_SCAN_ABORT_EN
  input  logic              abort_i,
`endif
  output logic              busy_o,
  output logic              pos_val_o,
  input  logic              pos_rdy_i,
  output logic [POS_WD-1:0] pos_o,
  output logic              done_o,
  output logic [POS_WD-1:0] cnt_o,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, OUT = 2'd2, DONE = 2'd3} state_t;

  localparam logic [POS_WD-1:0] NONE    = POS_WD'(DAT_WD + 1);
  localparam logic [POS_WD-1:0] MAX_CNT = POS_WD'(MAX_POS_NUM);

  state_t            state;
  logic [DAT_WD-1:0] mask_r;
  logic [POS_WD-1:0] det;
  logic [POS_WD-1:0] cnt_inc;
  logic [5:0]        clr_idx;
  logic              hs;
  logic              abort;

`ifdef LZ77_MATCH_SCAN_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  assign dbg_state = state;
  assign busy_o    = (state != IDLE);
  // Handshake: a position transfers on a cycle where pos_val_o && pos_rdy_i; pos_o is
  // held stable while valid is high and ready low; ready without valid is ignored.
  assign hs        = pos_val_o && pos_rdy_i;
  assign cnt_inc   = cnt_o + POS_WD'(1);
  assign clr_idx   = pos_o[5:0] - 6'd1;

  // Lowest-one detector; scanning from the top lets the lowest set bit win.
  always_comb begin
    det = NONE;
    for (int i = DAT_WD - 1; i >= 0; i--) begin
      if (mask_r[i]) det = POS_WD'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mask_r    <= '0;
      pos_o     <= '0;
      pos_val_o <= 1'b0;
      done_o    <= 1'b0;
      cnt_o     <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            mask_r <= mask_i;
            cnt_o  <= '0;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (abort) begin
            mask_r <= '0;
            done_o <= 1'b1;
            state  <= DONE;
          end else if (det == NONE) begin
            done_o <= 1'b1;
            state  <= DONE;
          end else begin
            pos_o     <= det;
            pos_val_o <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (hs) begin
            mask_r[clr_idx] <= 1'b0;
            cnt_o           <= cnt_inc;
            pos_val_o       <= 1'b0;
          end
          // Abort still lets a coincident handshake count, then drops the rest.
          if (abort) begin
            mask_r    <= '0;
            pos_val_o <= 1'b0;
            done_o    <= 1'b1;
            state     <= DONE;
          end else if (hs) begin
            if (cnt_inc == MAX_CNT) begin
              done_o <= 1'b1;
              state  <= DONE;
            end else begin
              state <= SCAN;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lz77_match_scan_ctrl.sv
// Directed bench for lz77_match_scan_ctrl: main instance at MAX_POS_NUM=64, second at 2.
// Abort scenario is compiled in when LZ77_MATCH_SCAN_ABORT_EN is defined.
module tb_lz77_match_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        start2;
  logic [63:0] mask;
  logic        rdy;
  logic        abort;

  logic        busy, val, done;
  logic [6:0]  pos, cnt;
  logic [1:0]  st;
  logic        busy2, val2, done2;
  logic [6:0]  pos2, cnt2;
  logic [1:0]  st2;

  int          checks   = 0;
  int          failures = 0;
  logic [6:0]  seq [8];

  lz77_match_scan_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .mask_i    (mask),
`ifdef LZ77_MATCH_SCAN_ABORT_EN
    .abort_i   (abort),
`endif
    .busy_o    (busy),
    .pos_val_o (val),
    .pos_rdy_i (rdy),
    .pos_o     (pos),
    .done_o    (done),
    .cnt_o     (cnt),
    .dbg_state (st)
  );

  lz77_match_scan_ctrl #(.MAX_POS_NUM(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start2),
    .mask_i    (mask),
`ifdef LZ77_MATCH_SCAN_ABORT_EN
    .abort_i   (1'b0),
`endif
    .busy_o    (busy2),
    .pos_val_o (val2),
    .pos_rdy_i (rdy),
    .pos_o     (pos2),
    .done_o    (done2),
    .cnt_o     (cnt2),
    .dbg_state (st2)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [6:0] p, input logic d);
    chk({tag, "_val"}, 64'(val), 64'(v));
    if (v) chk({tag, "_pos"}, 64'(pos), 64'(p));
    chk({tag, "_done"}, 64'(done), 64'(d));
  endtask

  // Start a scan with ready held high; positions come from seq[0..n-1].
  // pulse_k > 0 raises start_i (with a different mask) at that cycle to show it is ignored.
  task automatic run_seq(input string tag, input int n, input int pulse_k);
    logic v;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 2 * n + 2; k++) begin
      v = (k % 2 == 0) && (k <= 2 * n);
      chk_out($sformatf("%s_c%0d", tag, k), v, v ? seq[k/2-1] : 7'd0, k == 2 * n + 2);
      if (k == pulse_k) begin
        start = 1'b1;
        mask  = '1;
      end
      if (k < 2 * n + 2) begin
        step();
        start = 1'b0;
      end
    end
    chk({tag, "_cnt"}, 64'(cnt), 64'(n));
    step();
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; mask = '0; rdy = 1'b0; abort = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_val",  64'(val),  64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cnt",  64'(cnt),  64'd0);
    chk("rst_pos",  64'(pos),  64'd0);
    chk("rst_st",   64'(st),   64'd0);

    // empty mask: done at t+2, no valid
    mask = '0; rdy = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk("empty_busy1", 64'(busy), 64'd1);
    chk_out("empty_c1", 1'b0, 7'd0, 1'b0);
    step();
    chk("empty_busy2", 64'(busy), 64'd1);
    chk_out("empty_c2", 1'b0, 7'd0, 1'b1);
    chk("empty_cnt", 64'(cnt), 64'd0);
    step();
    chk("empty_busy3", 64'(busy), 64'd0);
    chk("empty_done3", 64'(done), 64'd0);

    // bits 0, 4, 63
    mask = 64'h8000_0000_0000_0011;
    seq[0] = 7'd1; seq[1] = 7'd5; seq[2] = 7'd64;
    run_seq("m811", 3, 0);

    // back-pressure: pos 9 held for 5 cycles
    mask = 64'h0000_0000_0000_0100; rdy = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk_out($sformatf("hold_c%0d", i), 1'b1, 7'd9, 1'b0);
      if (i < 4) step();
    end
    rdy = 1'b1;
    step();
    chk_out("hold_scan", 1'b0, 7'd0, 1'b0);
    chk("hold_cnt1", 64'(cnt), 64'd1);
    step();
    chk_out("hold_done", 1'b0, 7'd0, 1'b1);
    chk("hold_cnt2", 64'(cnt), 64'd1);
    step();

    // MAX_POS_NUM=2 instance on all-ones mask
    mask = '1; start2 = 1'b1;
    step();
    start2 = 1'b0;
    step();
    chk("max_v1", 64'(val2), 64'd1);
    chk("max_p1", 64'(pos2), 64'd1);
    step();
    chk("max_v_gap", 64'(val2), 64'd0);
    step();
    chk("max_v2", 64'(val2), 64'd1);
    chk("max_p2", 64'(pos2), 64'd2);
    step();
    chk("max_done", 64'(done2), 64'd1);
    chk("max_val3", 64'(val2), 64'd0);
    chk("max_cnt", 64'(cnt2), 64'd2);
    step();
    chk("max_busy", 64'(busy2), 64'd0);
    chk("max_done_off", 64'(done2), 64'd0);

    // reset mid-scan while pos 5 is pending
    mask = 64'h0F0; rdy = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk_out("mrst_pre", 1'b1, 7'd5, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_val",  64'(val),  64'd0);
    chk("mrst_pos",  64'(pos),  64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_cnt",  64'(cnt),  64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_st",   64'(st),   64'd0);

    // start pulsed during OUT is ignored
    mask = 64'h0F0; rdy = 1'b1;
    seq[0] = 7'd5; seq[1] = 7'd6; seq[2] = 7'd7; seq[3] = 7'd8;
    run_seq("mf0", 4, 2);

`ifdef LZ77_MATCH_SCAN_ABORT_EN
    mask = 64'h0F0; rdy = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk_out("ab_p5", 1'b1, 7'd5, 1'b0);
    step();
    rdy = 1'b0;
    step();
    chk_out("ab_p6", 1'b1, 7'd6, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_out("ab_done", 1'b0, 7'd0, 1'b1);
    chk("ab_cnt", 64'(cnt), 64'd1);
    step();
    chk("ab_busy", 64'(busy), 64'd0);
    rdy = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
